mgmt_arbiter: RTL and testbench

Two-master arbiter for the 32-bit management register bus (8-bit register address, fixed-latency read data). It lets the CPU-side 16-bit port bridge and a second master (HPS config path) share one register slave. It serialises their requests with round-robin fairness and returns read data to the master that issued the read. Masters see a waitrequest handshake; the slave side is a plain single-cycle read/write strobe bus.

---
 rtl/mgmt_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mgmt_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_arbiter.sv
// Round-robin arbiter letting two management masters share one register slave.
// Serialises requests; read data is routed back to the master that issued the read.
module mgmt_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  output logic        m0_waitrequest,
  input  logic [7:0]  m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic        m1_waitrequest,
  output logic [7:0]  s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  input  logic [31:0] s_readdata
);

  localparam logic [2:0] LP_LAT = 3'(RD_LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last, w_last_nxt;
  logic        r_grant, w_grant_nxt;
  logic        r_is_write, w_is_write_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;

  logic [7:0]  r_s_address, w_s_address_nxt;
  logic [31:0] r_s_writedata, w_s_writedata_nxt;
  logic        r_s_read, w_s_read_nxt;
  logic        r_s_write, w_s_write_nxt;
  logic [31:0] r_m0_readdata, w_m0_readdata_nxt;
  logic [31:0] r_m1_readdata, w_m1_readdata_nxt;
  logic        r_m0_rdv, w_m0_rdv_nxt;
  logic        r_m1_rdv, w_m1_rdv_nxt;
  logic        r_m0_wait, w_m0_wait_nxt;
  logic        r_m1_wait, w_m1_wait_nxt;

  logic        w_req0, w_req1, w_sel, w_sel_write;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;
  // Under contention the master that did not win last time goes first.
  assign w_sel       = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_sel_write = w_sel ? m1_write : m0_write;

  always_comb begin
    w_state_nxt       = r_state;
    w_last_nxt        = r_last;
    w_grant_nxt       = r_grant;
    w_is_write_nxt    = r_is_write;
    w_cnt_nxt         = r_cnt;
    w_s_address_nxt   = r_s_address;
    w_s_writedata_nxt = r_s_writedata;
    w_s_read_nxt      = 1'b0;
    w_s_write_nxt     = 1'b0;
    w_m0_readdata_nxt = r_m0_readdata;
    w_m1_readdata_nxt = r_m1_readdata;
    w_m0_rdv_nxt      = 1'b0;
    w_m1_rdv_nxt      = 1'b0;
    w_m0_wait_nxt     = 1'b1;
    w_m1_wait_nxt     = 1'b1;

    case (r_state)
      IDLE: begin
        if (w_req0 | w_req1) begin
          w_grant_nxt       = w_sel;
          if (w_req0 & w_req1) w_last_nxt = w_sel;
          w_is_write_nxt    = w_sel_write;
          w_s_address_nxt   = w_sel ? m1_address : m0_address;
          w_s_writedata_nxt = w_sel ? m1_writedata : m0_writedata;
          w_s_write_nxt     = w_sel_write;
          w_s_read_nxt      = ~w_sel_write;
          // A write completes in the same cycle its strobe reaches the slave.
          if (w_sel_write) begin
            if (w_sel) w_m1_wait_nxt = 1'b0;
            else       w_m0_wait_nxt = 1'b0;
          end
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (r_is_write) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = LP_LAT;
          w_state_nxt = RDWAIT;
        end
      end
      RDWAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            if (r_grant) begin
              w_m1_readdata_nxt = s_readdata;
              w_m1_rdv_nxt      = 1'b1;
              w_m1_wait_nxt     = 1'b0;
            end else begin
              w_m0_readdata_nxt = s_readdata;
              w_m0_rdv_nxt      = 1'b1;
              w_m0_wait_nxt     = 1'b0;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_last        <= 1'b1;
      r_grant       <= 1'b0;
      r_is_write    <= 1'b0;
      r_cnt         <= 3'd0;
      r_s_address   <= 8'h00;
      r_s_writedata <= 32'h0;
      r_s_read      <= 1'b0;
      r_s_write     <= 1'b0;
      r_m0_readdata <= 32'h0;
      r_m1_readdata <= 32'h0;
      r_m0_rdv      <= 1'b0;
      r_m1_rdv      <= 1'b0;
      r_m0_wait     <= 1'b1;
      r_m1_wait     <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_last        <= w_last_nxt;
      r_grant       <= w_grant_nxt;
      r_is_write    <= w_is_write_nxt;
      r_cnt         <= w_cnt_nxt;
      r_s_address   <= w_s_address_nxt;
      r_s_writedata <= w_s_writedata_nxt;
      r_s_read      <= w_s_read_nxt;
      r_s_write     <= w_s_write_nxt;
      r_m0_readdata <= w_m0_readdata_nxt;
      r_m1_readdata <= w_m1_readdata_nxt;
      r_m0_rdv      <= w_m0_rdv_nxt;
      r_m1_rdv      <= w_m1_rdv_nxt;
      r_m0_wait     <= w_m0_wait_nxt;
      r_m1_wait     <= w_m1_wait_nxt;
    end
  end

  assign s_address        = r_s_address;
  assign s_writedata      = r_s_writedata;
  assign s_read           = r_s_read;
  assign s_write          = r_s_write;
  assign m0_readdata      = r_m0_readdata;
  assign m1_readdata      = r_m1_readdata;
  assign m0_readdatavalid = r_m0_rdv;
  assign m1_readdatavalid = r_m1_rdv;
  assign m0_waitrequest   = r_m0_wait;
  assign m1_waitrequest   = r_m1_wait;

endmodule

// File: tb/tb_mgmt_arbiter.sv
// Scoreboard bench for mgmt_arbiter: stimulus queues expected slave strobes and
// master completions with their cycle numbers; a negedge monitor pops and compares.
module tb_mgmt_arbiter;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, s_writedata, s_readdata;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest;
  logic        s_read, s_write;

  mgmt_arbiter #(.RD_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; bit isWrite; logic [7:0] addr; logic [31:0] data; } slvExp_t;
  typedef struct { int cyc; bit isRead; logic [31:0] data; } cmpExp_t;

  slvExp_t     qSlv[$];
  cmpExp_t     qM0[$];
  cmpExp_t     qM1[$];
  int          nCompared = 0;
  int          nMismatched = 0;
  int          cyc = 0;
  logic [31:0] expRd0 = 32'h0;
  logic [31:0] expRd1 = 32'h0;
  logic [31:0] slaveMem [256];
  int          pendCyc = -1;
  logic [7:0]  pendAddr = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportUnexpected(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: got an output, expected none (cycle %0d)", name, cyc);
  endtask

  // Slave stub: register file whose read data is only valid LAT cycles after s_read.
  initial begin
    for (int i = 0; i < 256; i++) slaveMem[i] = 32'h5100_0000 | 32'(i);
    slaveMem[8'h05] = 32'hCAFE_0001;
  end

  always @(negedge clk) begin
    if (s_write) slaveMem[s_address] = s_writedata;
    if (s_read) begin
      pendCyc  = cyc + LAT;
      pendAddr = s_address;
    end
  end

  always @(posedge clk) begin
    #1;
    s_readdata = (cyc == pendCyc) ? slaveMem[pendAddr] : 32'hBAD0_0BAD;
  end

  task automatic monitorMaster(input int m, input logic waitReq, input logic rdv,
                               input logic [31:0] rdata, input logic [31:0] otherRdata);
    cmpExp_t e;
    if (!waitReq) begin
      if ((m == 0 ? qM0.size() : qM1.size()) == 0) begin
        reportUnexpected($sformatf("m%0d completion", m));
      end else begin
        if (m == 0) e = qM0.pop_front();
        else        e = qM1.pop_front();
        checkOutput($sformatf("m%0d completion cycle", m), 32'(cyc), 32'(e.cyc));
        checkOutput($sformatf("m%0d readdatavalid", m), 32'(rdv), 32'(e.isRead));
        if (e.isRead) begin
          if (m == 0) expRd0 = e.data;
          else        expRd1 = e.data;
        end
        checkOutput($sformatf("m%0d readdata", m), rdata, (m == 0) ? expRd0 : expRd1);
        checkOutput($sformatf("m%0d readdata held", 1 - m), otherRdata, (m == 0) ? expRd1 : expRd0);
      end
    end else if (rdv) begin
      reportUnexpected($sformatf("m%0d readdatavalid while waitrequest high", m));
    end
  endtask

  always @(negedge clk) begin
    slvExp_t s;
    if (s_read || s_write) begin
      if (qSlv.size() == 0) begin
        reportUnexpected("slave strobe");
      end else begin
        s = qSlv.pop_front();
        checkOutput("slave strobe cycle", 32'(cyc), 32'(s.cyc));
        checkOutput("slave s_write", 32'(s_write), 32'(s.isWrite));
        checkOutput("slave s_read", 32'(s_read), 32'(!s.isWrite));
        checkOutput("slave s_address", 32'(s_address), 32'(s.addr));
        if (s.isWrite) checkOutput("slave s_writedata", s_writedata, s.data);
      end
    end
    monitorMaster(0, m0_waitrequest, m0_readdatavalid, m0_readdata, m1_readdata);
    monitorMaster(1, m1_waitrequest, m1_readdatavalid, m1_readdata, m0_readdata);
  end

  task automatic nextCyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic driveMaster(input int m, input logic rd, input logic wr,
                             input logic [7:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
    end
  endtask

  task automatic pushCompletion(input int m, input int c, input bit isRead, input logic [31:0] d);
    cmpExp_t e;
    e.cyc = c; e.isRead = isRead; e.data = d;
    if (m == 0) qM0.push_back(e);
    else        qM1.push_back(e);
  endtask

  task automatic pushSlave(input int c, input bit isWrite, input logic [7:0] a, input logic [31:0] d);
    slvExp_t s;
    s.cyc = c; s.isWrite = isWrite; s.addr = a; s.data = d;
    qSlv.push_back(s);
  endtask

  // Isolated transaction on an idle bus, issued in the current cycle (T0).
  task automatic applyStimulus(input int m, input logic rd, input logic wr, input logic [7:0] a,
                               input logic [31:0] d, input logic [31:0] expRead);
    int c, comp;
    c = cyc;
    driveMaster(m, rd, wr, a, d);
    pushSlave(c + 1, wr, a, d);
    comp = wr ? c + 1 : c + 2 + LAT;
    pushCompletion(m, comp, !wr, expRead);
    nextCyc(comp + 1 - c);
    driveMaster(m, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  // Both masters hold writes; the arbiter is expected to start with m0 and alternate.
  task automatic contend(input int n, input logic [7:0] a0, input logic [7:0] a1);
    int c;
    c = cyc;
    driveMaster(0, 1'b0, 1'b1, a0, 32'hA0A0_0000 | 32'(a0));
    driveMaster(1, 1'b0, 1'b1, a1, 32'hB1B1_0000 | 32'(a1));
    for (int k = 0; k < n; k++) begin
      pushSlave(c + 1 + 2 * k, 1'b1, (k % 2 == 0) ? a0 : a1,
                (k % 2 == 0) ? (32'hA0A0_0000 | 32'(a0)) : (32'hB1B1_0000 | 32'(a1)));
      pushCompletion(k % 2, c + 1 + 2 * k, 1'b0, 32'h0);
    end
    nextCyc(2 * n);
    driveMaster(0, 1'b0, 1'b0, 8'h00, 32'h0);
    driveMaster(1, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    rst_n = 1'b0;
    driveMaster(0, 1'b0, 1'b0, 8'h00, 32'h0);
    driveMaster(1, 1'b0, 1'b0, 8'h00, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset s_address", 32'(s_address), 32'h0);
    checkOutput("reset s_writedata", s_writedata, 32'h0);
    checkOutput("reset s_read", 32'(s_read), 32'h0);
    checkOutput("reset s_write", 32'(s_write), 32'h0);
    checkOutput("reset m0_readdata", m0_readdata, 32'h0);
    checkOutput("reset m1_readdata", m1_readdata, 32'h0);
    checkOutput("reset m0_readdatavalid", 32'(m0_readdatavalid), 32'h0);
    checkOutput("reset m1_readdatavalid", 32'(m1_readdatavalid), 32'h0);
    checkOutput("reset m0_waitrequest", 32'(m0_waitrequest), 32'h1);
    checkOutput("reset m1_waitrequest", 32'(m1_waitrequest), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nextCyc(1);

    $display("[TB] contention after reset");
    contend(4, 8'h30, 8'h31);

    $display("[TB] single transactions");
    applyStimulus(0, 1'b0, 1'b1, 8'h12, 32'hDEAD_BEEF, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 8'h05, 32'h0, 32'hCAFE_0001);
    applyStimulus(0, 1'b1, 1'b1, 8'h20, 32'h1234_5678, 32'h0);
    applyStimulus(0, 1'b0, 1'b1, 8'hFF, 32'hFFFF_FFFF, 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 8'hFF, 32'h0, 32'hFFFF_FFFF);
    applyStimulus(1, 1'b1, 1'b0, 8'h20, 32'h0, 32'h1234_5678);

    $display("[TB] contention leaving m0 as last winner");
    contend(3, 8'h40, 8'h41);

    $display("[TB] reset during read wait");
    c = cyc;
    driveMaster(0, 1'b1, 1'b0, 8'h05, 32'h0);
    pushSlave(c + 1, 1'b0, 8'h05, 32'h0);
    nextCyc(2);
    rst_n = 1'b0;
    driveMaster(0, 1'b0, 1'b0, 8'h00, 32'h0);
    nextCyc(1);
    @(negedge clk);
    checkOutput("mid-read reset s_read", 32'(s_read), 32'h0);
    checkOutput("mid-read reset m0_waitrequest", 32'(m0_waitrequest), 32'h1);
    checkOutput("mid-read reset m1_waitrequest", 32'(m1_waitrequest), 32'h1);
    checkOutput("mid-read reset m0_readdatavalid", 32'(m0_readdatavalid), 32'h0);
    checkOutput("mid-read reset m0_readdata", m0_readdata, 32'h0);
    checkOutput("mid-read reset m1_readdata", m1_readdata, 32'h0);
    expRd0 = 32'h0;
    expRd1 = 32'h0;
    nextCyc(2);
    rst_n = 1'b1;
    nextCyc(1);

    $display("[TB] contention after mid-read reset");
    contend(2, 8'h50, 8'h51);

    nextCyc(8);
    checkOutput("slave strobes outstanding", 32'(qSlv.size()), 32'h0);
    checkOutput("m0 completions outstanding", 32'(qM0.size()), 32'h0);
    checkOutput("m1 completions outstanding", 32'(qM1.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
